dec_unbinder_seq: RTL
=====================

// Module: dec_unbinder_seq
// PURPOSE
// - Decode-side inverse of the encoder binder pack. The binder pack cyclically rotates each
//   feature's level HV LEFT by its per-feature shift SHIFTS[i]; this block undoes that rotation.
// - Snapshots a full bank of FEATURES_PER_CC bound HVs on start_decoding.
// - Streams the recovered level HVs out one per accepted beat, in feature order 0..F-1,
//   on a valid/ready interface toward the decoder/similarity stage.
// PARAMETERS
// - HV_DIM           1024   hypervector width in bits
// - FEATURES_PER_CC  8      features handled per compute cluster (bank depth, F)
// - SHIFT_W          10     width of one shift entry, = $clog2(HV_DIM)
// - IDX_W            3      feature index width, = $clog2(FEATURES_PER_CC), min 1
// PORTS
// - clk             in   1                        rising-edge clock
// - rst             in   1                        synchronous, active-high reset
// - start_decoding  in   1                        request to capture the bank (qualified by en)
// - en              in   1                        cluster enable; low = freeze, no capture
// - shifted_hv      in   HV_DIM x [0:F-1]         bound (rotated) HVs, sampled on capture only
// - busy            out  1                        high from capture until done
// - out_valid       out  1                        level_hv/out_idx hold a valid beat
// - out_ready       in   1                        downstream accepts beat when out_valid&&out_ready
// - out_idx         out  IDX_W                    feature index of current beat
// - level_hv        out  HV_DIM                   recovered HV = rotr(shifted_hv[idx], SHIFTS[idx])
// - done            out  1                        1-cycle pulse after the last beat is accepted
// BEHAVIOUR
// - Reset values (rst=1 at a clk edge):
//   - state=IDLE; busy=0, out_valid=0, done=0, out_idx=0, level_hv=0, read index=0.
//   - The bank contents are don't-care.
// - FSM states:
//   - IDLE: start_decoding&&en -> copy all F inputs into the bank, read index=0, busy=1, go to RUN.
//   - RUN: issue beats per the output-register rule below; idle in RUN when en=0.
//   - DONE: one cycle; done=1, busy=0; return to IDLE.
// - Output register (RUN, en=1):
//   - Loads when (!out_valid || out_ready) and read index < F.
//   - Load writes level_hv = rotr(bank[idx], SHIFTS[idx]), out_idx=idx, out_valid=1, then idx++.
//   - out_valid cleared on acceptance when no new load occurs.
//   - Full rate: 1 beat/cycle while out_ready=1.
// - Latency:
//   - Capture edge = cycle 0. out_valid rises at cycle 1 (first load at the first RUN edge).
//   - With out_ready held high, beat k is valid in cycle k+1.
//   - Last beat accepted in cycle F. done=1 in cycle F+1. busy falls with done.
// - Backpressure: while out_valid && !out_ready, level_hv/out_idx/out_valid hold stable and idx does not advance.
// - en=0 while busy:
//   - No loads, no idx advance, no state change.
//   - A pending beat stays valid and may still be accepted.
// - start_decoding while busy or in DONE is ignored; the bank is never overwritten mid-batch.
// - start_decoding with en=0 is ignored.
// - Arithmetic:
//   - rotr is a pure cyclic rotate: bit j of the result = bank bit (j+s) mod HV_DIM.
//   - s = SHIFTS[idx] mod HV_DIM. s=0 is a pass-through.
//   - Combinational single-cycle barrel rotate feeding the output register.
// - Index wrap: idx counts 0..F. idx==F means "all issued". RUN->DONE when idx==F and the final beat is accepted.
// - Reset mid-batch: aborts immediately to reset values. No done pulse; the partial batch is discarded.
// - Simultaneous rst and start_decoding: rst wins.
// STRUCTURE
// - Shared package (hdc_pkg):
//   - HV_DIM, FEATURES_PER_CC, SHIFT_W.
//   - SHIFTS as logic [SHIFT_W-1:0] SHIFTS [0:FEATURES_PER_CC-1], the same table the encoder binders use.
//   - typedef hv_t = logic [HV_DIM-1:0].
//   - typedef enum dec_state_t {IDLE, RUN, DONE}.
// - One sub-module: hv_rotr, a parameterised combinational cyclic right-rotate (hv in, shift in, hv out).
//   - The encoder-side rotate mirrors it.
// - Top holds the bank, idx counter, FSM and output register.
// TESTING
// - Round trip:
//   - Stimulus: random level HVs pass through the encoder binder pack; feed the results in; out_ready=1.
//   - Response: beats 0..F-1 equal the originals in cycles 1..F; done=1 in cycle F+1.
// - Known vector:
//   - Stimulus: HV_DIM=16, SHIFTS[0]=3, shifted_hv[0]=16'h0008.
//   - Response: beat 0 level_hv=16'h0001, out_idx=0.
// - Backpressure:
//   - Stimulus: out_ready=0 for cycles 1..4, then 1.
//   - Response: beat 0 held stable 4 cycles; no beat skipped or duplicated; done at cycle F+5.
// - en stall:
//   - Stimulus: en=0 for 3 cycles mid-batch.
//   - Response: idx frozen; output stream resumes at the next index; total beats = F.
// - Ignored start:
//   - Stimulus: start_decoding pulses while busy with changed shifted_hv.
//   - Response: outputs still match the first snapshot.
// - Reset mid-op:
//   - Stimulus: rst at beat 2.
//   - Response: next cycle busy=0, out_valid=0, done never pulses; a fresh start then yields a correct full batch.

Source files
------------

// File: rtl/hdc_pkg.sv
// Shared HDC constants and types: bank geometry, the per-feature binder shift
// table (identical to the encoder side), the HV type and the decoder FSM states.
package hdc_pkg;

  localparam int unsigned HV_DIM          = 1024;
  localparam int unsigned FEATURES_PER_CC = 8;
  localparam int unsigned SHIFT_W         = $clog2(HV_DIM);
  localparam int unsigned IDX_W           = (FEATURES_PER_CC > 1) ? $clog2(FEATURES_PER_CC) : 1;

  localparam logic [SHIFT_W-1:0] SHIFTS [0:FEATURES_PER_CC-1] = '{
    10'd0, 10'd1, 10'd7, 10'd64, 10'd511, 10'd512, 10'd1000, 10'd1023
  };

  typedef logic [HV_DIM-1:0] hv_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} dec_state_t;

endpackage

// File: rtl/dec_unbinder_seq_if.sv
// Valid/ready beat stream carrying one recovered level HV and its feature index.
interface dec_unbinder_seq_if;
  import hdc_pkg::*;

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  hv_t              level_hv;

  modport master (output out_valid, output out_idx, output level_hv, input out_ready);
  modport slave  (input out_valid, input out_idx, input level_hv, output out_ready);

endinterface

// File: rtl/hv_rotr.sv
// Combinational cyclic right-rotate: bit j of rot = hv[(j + shift) mod W].
module hv_rotr #(
  parameter int unsigned W  = 1024,
  parameter int unsigned SW = 10
) (
  input  logic [W-1:0]  hv,
  input  logic [SW-1:0] shift,
  output logic [W-1:0]  rot
);

  logic [31:0] s;

  // s == 0 makes the left term a shift by W, which is zero, so no special case
  assign s   = 32'(shift) % W;
  assign rot = (hv >> s) | (hv << (W - s));

endmodule

// File: rtl/dec_unbinder_seq.sv
// Snapshots a bank of bound HVs and streams them out un-rotated, one per
// accepted beat, in feature order.
module dec_unbinder_seq
  import hdc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_decoding,
  input  logic              en,
  input  hv_t               shifted_hv [0:FEATURES_PER_CC-1],
  output logic              busy,
  output logic              done,
  dec_unbinder_seq_if.master stream
);

  dec_state_t       state;
  hv_t              bank [0:FEATURES_PER_CC-1];
  logic [IDX_W:0]   idx;
  logic [IDX_W-1:0] sel;
  hv_t              rot;
  logic             all_issued;
  logic             can_take;
  logic             accept;
  logic             load;
  logic             capture;

  assign sel        = idx[IDX_W-1:0];
  assign all_issued = (idx == (IDX_W+1)'(FEATURES_PER_CC));
  assign can_take   = !stream.out_valid || stream.out_ready;
  assign accept     = stream.out_valid && stream.out_ready;
  assign load       = (state == RUN) && en && can_take && !all_issued;
  assign capture    = (state == IDLE) && start_decoding && en;

  hv_rotr #(.W(HV_DIM), .SW(SHIFT_W)) u_rotr (
    .hv    (bank[sel]),
    .shift (SHIFTS[sel]),
    .rot   (rot)
  );

  // Bank content is don't-care out of reset, so it carries no reset term
  always_ff @(posedge clk) begin
    if (capture && !rst) begin
      for (int unsigned i = 0; i < FEATURES_PER_CC; i++) begin
        bank[i] <= shifted_hv[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      idx              <= '0;
      stream.out_valid <= 1'b0;
      stream.out_idx   <= '0;
      stream.level_hv  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Acceptance is honoured even while en is low; only loads stall
          if (load) begin
            stream.level_hv  <= rot;
            stream.out_idx   <= sel;
            stream.out_valid <= 1'b1;
            idx              <= idx + (IDX_W+1)'(1);
          end else if (accept) begin
            stream.out_valid <= 1'b0;
          end
          if (en && all_issued && can_take) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
